if_stage: RTL and testbench
===========================

# if_stage

Instruction fetch stage: owns the program counter, issues word fetches to instruction memory over a valid/ready request port, and buffers returned instructions in an in-order prefetch FIFO. Sits immediately upstream of the IF/ID pipeline register and drives its `is_valid_in`/`pc_in`/`instr_in`. It honours the pipeline's stall and flush/redirect controls and discards in-flight responses belonging to the flushed path.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset; must be word-aligned.
- `DEPTH`, default 4: total fetch credits, a power of two ≥ 2. It bounds the sum of outstanding requests plus FIFO occupancy.
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `is_stall` in 1: downstream cannot accept; hold the FIFO head.
- `is_flush` in 1: squash the fetch path; redirect to `redirect_pc`.
- `redirect_pc` in 32: new fetch address, sampled when `is_flush`=1; word-aligned.
- `imem_req_valid` out 1: fetch request.
- `imem_req_ready` in 1: memory accepts the request this cycle.
- `imem_req_addr` out 32: fetch address, equal to `fetch_pc`.
- `imem_rsp_valid` in 1: response word valid, returned in request order.
- `imem_rsp_data` in 32: instruction word.
- `is_valid_out` out 1: FIFO head valid.
- `pc_out` out 32: PC of the FIFO head.
- `instr_out` out 32: instruction at the FIFO head.

## Operation
- **State**
  - `fetch_pc` (32b).
  - Pending-PC queue (DEPTH entries): PCs of issued, unanswered, live requests.
  - Output FIFO (DEPTH entries of {pc, instr}).
  - `drop_cnt`: count of outstanding requests from the squashed path.
- **Credit check:** `used = pend_cnt + fifo_cnt + drop_cnt`.
- **Request:** `imem_req_valid = !reset && !is_flush && used < DEPTH`. Drive it only from registered state plus `is_flush`.
  - On handshake (`valid && ready`): push `fetch_pc` to the pending queue; `fetch_pc += 4`, wrapping modulo 2^32.
  - `imem_req_addr` has no hold requirement. The memory samples it only on handshake.
- **Response:** on `imem_rsp_valid`:
  - If `drop_cnt > 0`: decrement `drop_cnt` and discard the word.
  - Else if `pend_cnt > 0`: pop the pending PC and push {pc, `imem_rsp_data`} into the FIFO.
  - Else: ignore the response (protocol error; the bench asserts it never happens).
- **Output:** `is_valid_out = fifo_cnt != 0`. `pc_out`/`instr_out` are the FIFO head, driven from registers with no combinational path from memory.
  - Pop when `is_valid_out && !is_stall && !is_flush`.
  - When the FIFO is empty, `pc_out`/`instr_out` hold their last values. Don't-care, but never X after reset.
- **Flush** (overrides stall and the same-cycle pop):
  - `fetch_pc <= redirect_pc`.
  - Output FIFO and pending queue are cleared.
  - `drop_cnt <= drop_cnt + pend_cnt - (imem_rsp_valid ? 1 : 0)`. A response arriving in the flush cycle is itself discarded.
  - No request is issued in the flush cycle.
- **Stall:** the FIFO head is held stable. Requests continue until credits are exhausted, and responses continue to fill the FIFO.
- **Reset:**
  - `fetch_pc = RESET_PC`; all counts 0.
  - `is_valid_out = 0`, `pc_out = 0`, `instr_out = 0`, `imem_req_valid = 0` during the reset cycle.
  - Instruction memory shares `reset`, so no pre-reset response arrives after reset. Reset mid-operation therefore needs no drop tracking.
- **Overflow:** the FIFO cannot overflow. Credits reserve a FIFO slot for every outstanding request.

## Timing
- **Minimum latency:** request handshake in cycle N, response at N+1 or later. The response is written into the FIFO at the end of its arrival cycle, so `is_valid_out` rises no earlier than N+2. There is no bypass.
- **Throughput:** one instruction per cycle when `DEPTH ≥ L+2`, where L is the memory response latency. The default DEPTH=4 sustains this for L ≤ 2.
- **After flush in cycle F:**
  - First redirect request is offered in F+1.
  - `is_valid_out` = 0 in F+1.
  - First redirect instruction is valid at F+3 or later with L=1.
- **First fetch after reset:** the first request is offered in the first cycle with `reset`=0.

## Test plan
1. **Reset and sequential fetch.** Setup: `RESET_PC`=0, 1-cycle memory returning `instr = addr ^ 32'hA5A5_0000`, `is_stall`=0.
   - Requests are issued at addresses 0, 4, 8, ...
   - Outputs show (0, A5A5_0000), (4, A5A5_0004), ... on consecutive cycles.
   - First valid appears 2 cycles after the first handshake.
2. **Stall.** Hold `is_stall` for 5 cycles mid-stream.
   - Head pc/instr stay constant.
   - `imem_req_valid` drops once `used`=4.
   - After release, the PC sequence continues with no gap and no duplicate.
3. **Flush with in-flight requests.** Setup: 2-cycle memory, two requests outstanding; pulse `is_flush` with `redirect_pc`=0x100.
   - Both stale responses are discarded.
   - Next valid `pc_out` = 0x100, followed by 0x104.
4. **Backpressure.** Hold `imem_req_ready`=0 for 4 cycles.
   - `imem_req_addr` and `fetch_pc` do not advance.
   - Resumes at the same address once ready returns.
5. **Simultaneous events.** Flush, stall and `imem_rsp_valid` asserted in the same cycle.
   - The response is dropped.
   - `drop_cnt` is computed correctly, with no extra word discarded later.
   - Next valid pc = `redirect_pc`.
6. **Reset mid-stream.** Assert `reset` with a full FIFO and requests outstanding.
   - Next cycle: `is_valid_out`=0 and outputs are zero.
   - Fetch restarts at `RESET_PC`.
   - Credits are restored to `DEPTH`.

Source files
------------

// File: rtl/if_stage.sv
// Instruction fetch stage: PC generation, credit-limited fetch requests and an
// in-order prefetch FIFO feeding the IF/ID register, with flush/redirect support.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        is_stall,
  input  logic        is_flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        is_valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] instr_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int UW = AW + 2;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pend_pc_q [DEPTH];
  logic [AW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic [31:0]   fifo_pc_q [DEPTH];
  logic [31:0]   fifo_instr_q [DEPTH];
  logic [AW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic [UW-1:0] used;
  logic          req_fire;
  logic          rsp_drop;
  logic          rsp_take;
  logic          fifo_nonempty;
  logic          pop;
  logic [AW-1:0] head_idx;

  assign used          = UW'(pend_cnt_q) + UW'(fifo_cnt_q) + UW'(drop_cnt_q);
  assign imem_req_valid = !reset && !is_flush && (used < UW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_take = imem_rsp_valid && (drop_cnt_q == '0) && (pend_cnt_q != '0) && !is_flush;

  assign fifo_nonempty = fifo_cnt_q != '0;
  assign pop           = fifo_nonempty && !is_stall && !is_flush;

  // When empty, show the most recently popped entry so the outputs hold.
  assign head_idx     = fifo_nonempty ? fifo_rd_q : fifo_rd_q - 1'b1;
  assign is_valid_out = !reset && fifo_nonempty;
  assign pc_out       = reset ? '0 : fifo_pc_q[head_idx];
  assign instr_out    = reset ? '0 : fifo_instr_q[head_idx];

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pend_wr_d  = pend_wr_q;
    pend_rd_d  = pend_rd_q;
    pend_cnt_d = pend_cnt_q;
    fifo_wr_d  = fifo_wr_q;
    fifo_rd_d  = fifo_rd_q;
    fifo_cnt_d = fifo_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if (is_flush) begin
      fetch_pc_d = redirect_pc;
      pend_rd_d  = pend_wr_q;
      pend_cnt_d = '0;
      fifo_wr_d  = fifo_rd_q;
      fifo_cnt_d = '0;
      // Every live request becomes stale; a response landing now is one of them.
      if (imem_rsp_valid && ((drop_cnt_q != '0) || (pend_cnt_q != '0)))
        drop_cnt_d = drop_cnt_q + pend_cnt_q - 1'b1;
      else
        drop_cnt_d = drop_cnt_q + pend_cnt_q;
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        pend_wr_d  = pend_wr_q + 1'b1;
      end
      if (rsp_take) begin
        pend_rd_d = pend_rd_q + 1'b1;
        fifo_wr_d = fifo_wr_q + 1'b1;
      end
      if (pop)
        fifo_rd_d = fifo_rd_q + 1'b1;
      pend_cnt_d = pend_cnt_q + CW'(req_fire) - CW'(rsp_take);
      fifo_cnt_d = fifo_cnt_q + CW'(rsp_take) - CW'(pop);
      drop_cnt_d = drop_cnt_q - CW'(rsp_drop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pend_wr_q  <= '0;
      pend_rd_q  <= '0;
      pend_cnt_q <= '0;
      fifo_wr_q  <= '0;
      fifo_rd_q  <= '0;
      fifo_cnt_q <= '0;
      drop_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_q[i]    <= '0;
        fifo_instr_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pend_wr_q  <= pend_wr_d;
      pend_rd_q  <= pend_rd_d;
      pend_cnt_q <= pend_cnt_d;
      fifo_wr_q  <= fifo_wr_d;
      fifo_rd_q  <= fifo_rd_d;
      fifo_cnt_q <= fifo_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      if (rsp_take) begin
        fifo_pc_q[fifo_wr_q]    <= pend_pc_q[pend_rd_q];
        fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire)
      pend_pc_q[pend_wr_q] <= fetch_pc_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: cycle table for streaming/stall/backpressure,
// plus hand sequences for flush, simultaneous events and mid-stream reset.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        is_stall = 1'b0;
  logic        is_flush = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        is_valid_out;
  logic [31:0] pc_out;
  logic [31:0] instr_out;

  int checks = 0;
  int errors = 0;
  int lat = 1;

  localparam logic [31:0] XORK = 32'hA5A5_0000;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .is_stall      (is_stall),
    .is_flush      (is_flush),
    .redirect_pc   (redirect_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .is_valid_out  (is_valid_out),
    .pc_out        (pc_out),
    .instr_out     (instr_out)
  );

  always #5 clk = ~clk;

  // Memory model: fixed latency of 1 or 2 cycles, shares reset with the DUT.
  logic [1:0]  mv;
  logic [31:0] ma [2];
  always @(posedge clk) begin
    if (reset) begin
      mv <= '0;
    end else begin
      mv[0] <= imem_req_valid && imem_req_ready;
      ma[0] <= imem_req_addr;
      mv[1] <= mv[0];
      ma[1] <= ma[0];
    end
  end
  assign imem_rsp_valid = (lat == 1) ? mv[0] : mv[1];
  assign imem_rsp_data  = ((lat == 1) ? ma[0] : ma[1]) ^ XORK;

  typedef struct {
    logic        stall;
    logic        ready;
    logic        ev;
    logic [31:0] epc;
    logic        erv;
    logic [31:0] eaddr;
  } vec_t;

  vec_t vecs [22];

  function automatic vec_t mk(logic s, logic r, logic ev, logic [31:0] pc, logic rv, logic [31:0] a);
    vec_t v;
    v.stall = s; v.ready = r; v.ev = ev; v.epc = pc; v.erv = rv; v.eaddr = a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic ev, input logic [31:0] epc);
    chk({tag, " valid"}, 32'(is_valid_out), 32'(ev));
    if (ev) begin
      chk({tag, " pc"}, pc_out, epc);
      chk({tag, " instr"}, instr_out, epc ^ XORK);
    end
  endtask

  task automatic chk_req(input string tag, input logic erv, input logic [31:0] eaddr);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'(erv));
    if (erv) chk({tag, " req_addr"}, imem_req_addr, eaddr);
  endtask

  task automatic step(input logic rst, input logic st, input logic fl, input logic rdy,
                      input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset = rst; is_stall = st; is_flush = fl; imem_req_ready = rdy; redirect_pc = rpc;
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " valid"}, 32'(is_valid_out), 32'h0);
    chk({tag, " pc"}, pc_out, 32'h0);
    chk({tag, " instr"}, instr_out, 32'h0);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // stall ready | valid pc | req_valid addr
    vecs[0]  = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h00);
    vecs[1]  = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h04);
    vecs[2]  = mk(1'b0, 1'b1, 1'b1, 32'h00, 1'b1, 32'h08);
    vecs[3]  = mk(1'b0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h0C);
    vecs[4]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h10);
    vecs[5]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h14);
    vecs[6]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00);
    vecs[7]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00);
    vecs[8]  = mk(1'b1, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00);
    vecs[9]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 1'b0, 32'h00);
    vecs[10] = mk(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h18);
    vecs[11] = mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h1C);
    vecs[12] = mk(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h20);
    vecs[13] = mk(1'b0, 1'b1, 1'b1, 32'h18, 1'b1, 32'h24);
    vecs[14] = mk(1'b0, 1'b0, 1'b1, 32'h1C, 1'b1, 32'h28);
    vecs[15] = mk(1'b0, 1'b0, 1'b1, 32'h20, 1'b1, 32'h28);
    vecs[16] = mk(1'b0, 1'b0, 1'b1, 32'h24, 1'b1, 32'h28);
    vecs[17] = mk(1'b0, 1'b0, 1'b0, 32'h00, 1'b1, 32'h28);
    vecs[18] = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h28);
    vecs[19] = mk(1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h2C);
    vecs[20] = mk(1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 32'h30);
    vecs[21] = mk(1'b0, 1'b1, 1'b1, 32'h2C, 1'b1, 32'h34);

    // Reset cycles, then streaming / stall / backpressure table (1-cycle memory)
    lat = 1;
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_reset_outputs("rst0");
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 22; i++) begin
      step(1'b0, vecs[i].stall, 1'b0, vecs[i].ready, 32'h0);
      chk_out($sformatf("tbl c%0d", i), vecs[i].ev, vecs[i].epc);
      chk_req($sformatf("tbl c%0d", i), vecs[i].erv, vecs[i].eaddr);
    end

    // Flush with two requests in flight, 2-cycle memory
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    lat = 2;
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_req("fl c0", 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_req("fl c1", 1'b1, 32'h4);
    step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100);
    chk_req("fl c2", 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("fl c3", 1'b0, 32'h0);
    chk_req("fl c3", 1'b1, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("fl c4", 1'b0, 32'h0);
    chk_req("fl c4", 1'b1, 32'h104);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("fl c5", 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("fl c6", 1'b1, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("fl c7", 1'b1, 32'h104);

    // Flush + stall + response in the same cycle, 1-cycle memory
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    lat = 1;
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk_out("sim c2", 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h200);
    chk_out("sim c3", 1'b1, 32'h0);
    chk_req("sim c3", 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("sim c4", 1'b0, 32'h0);
    chk_req("sim c4", 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("sim c5", 1'b0, 32'h0);
    chk_req("sim c5", 1'b1, 32'h204);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("sim c6", 1'b1, 32'h200);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk_out("sim c7", 1'b1, 32'h204);

    // Reset with three FIFO entries and one request outstanding
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk_out("mrs c3", 1'b1, 32'h0);
    chk_req("mrs c3", 1'b1, 32'hC);
    step(1'b1, 1'b1, 1'b0, 1'b1, 32'h0);
    chk_reset_outputs("mrs rst");
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk("mrs r0 valid", 32'(is_valid_out), 32'h0);
    chk("mrs r0 pc", pc_out, 32'h0);
    chk("mrs r0 instr", instr_out, 32'h0);
    chk_req("mrs r0", 1'b1, 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk_req("mrs r1", 1'b1, 32'h4);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk_out("mrs r2", 1'b1, 32'h0);
    chk_req("mrs r2", 1'b1, 32'h8);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk_req("mrs r3", 1'b1, 32'hC);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
    chk_out("mrs r4", 1'b1, 32'h0);
    chk_req("mrs r4", 1'b0, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
